// File: rtl/buffer_read_responder.sv
// buffer_read_responder: round-robin read server that broadcasts shared buffer words to row routers.
// Optional feature: define RESPONDER_MULTICAST_EN to pulse every requester sharing the winner's address.
module buffer_read_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUF_DEPTH   = 64,
  parameter int NUM_ROUTERS = 4,
  localparam int ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_en,
  input  logic                            i_reg_clear,
  input  logic                            i_wr_en,
  input  logic [ADDR_WIDTH-1:0]           i_wr_addr,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  input  logic [NUM_ROUTERS-1:0]          i_valid_addr,
  input  logic [NUM_ROUTERS*ADDR_WIDTH-1:0] i_read_addr,
  output logic [NUM_ROUTERS-1:0]          o_peek_en,
  output logic [NUM_ROUTERS-1:0]          o_data_hit,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_busy
);

  localparam int PTR_W = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEEK   = 3'd1,
    ST_SELECT = 3'd2,
    ST_READ   = 3'd3,
    ST_HIT    = 3'd4
  } state_t;

  state_t                  state_reg;
  logic [PTR_W-1:0]        rr_ptr_reg;
  logic [PTR_W-1:0]        win_idx_reg;
  logic [ADDR_WIDTH-1:0]   win_addr_reg;
  logic [NUM_ROUTERS-1:0]  hit_mask_reg;
  logic [NUM_ROUTERS-1:0]  peek_en_reg;
  logic [NUM_ROUTERS-1:0]  data_hit_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    busy_reg;

  logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];

  logic [ADDR_WIDTH-1:0]   req_addr [NUM_ROUTERS];
  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [NUM_ROUTERS-1:0]  match_mask;
  logic [PTR_W-1:0]        rr_next;

  // Storage has no reset so loaded contents survive reset and soft clear.
  always_ff @(posedge i_clk) begin
    if (i_nrst && i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROUTERS; gi++) begin : g_req
      assign req_addr[gi] = i_read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // First valid router at or after the round-robin pointer, wrapping around.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_ROUTERS; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_ROUTERS) begin
        cand = cand - NUM_ROUTERS;
      end
      cand_idx = PTR_W'(cand);
      if (!win_found && i_valid_addr[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_addr = req_addr[win_idx];

  generate
    for (gi = 0; gi < NUM_ROUTERS; gi++) begin : g_match
`ifdef RESPONDER_MULTICAST_EN
      assign match_mask[gi] = win_found && i_valid_addr[gi] && (req_addr[gi] == win_addr);
`else
      assign match_mask[gi] = win_found && (win_idx == PTR_W'(gi));
`endif
    end
  endgenerate

  assign rr_next = (win_idx_reg == PTR_W'(NUM_ROUTERS - 1)) ? '0 : win_idx_reg + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      win_idx_reg  <= '0;
      win_addr_reg <= '0;
      hit_mask_reg <= '0;
      peek_en_reg  <= '0;
      data_hit_reg <= '0;
      data_reg     <= '0;
      busy_reg     <= 1'b0;
    end else begin
      peek_en_reg  <= '0;
      data_hit_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (i_en) begin
            state_reg   <= ST_PEEK;
            peek_en_reg <= '1;
            busy_reg    <= 1'b1;
          end
        end
        ST_PEEK: begin
          state_reg <= ST_SELECT;
        end
        ST_SELECT: begin
          if (win_found) begin
            state_reg    <= ST_READ;
            win_idx_reg  <= win_idx;
            win_addr_reg <= win_addr;
            hit_mask_reg <= match_mask;
          end else if (i_en) begin
            state_reg   <= ST_PEEK;
            peek_en_reg <= '1;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_READ: begin
          // Registered read; a same-cycle write lands after this sample, so old data is returned.
          state_reg    <= ST_HIT;
          data_reg     <= mem[win_addr_reg];
          data_hit_reg <= hit_mask_reg;
        end
        ST_HIT: begin
          rr_ptr_reg <= rr_next;
          if (i_en) begin
            state_reg   <= ST_PEEK;
            peek_en_reg <= '1;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_peek_en  = peek_en_reg;
  assign o_data_hit = data_hit_reg;
  assign o_data     = data_reg;
  assign o_busy     = busy_reg;

endmodule

// File: tb/tb_buffer_read_responder.sv
// Directed self-checking bench for buffer_read_responder (default parameters).
module tb_buffer_read_responder;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           nrst;
  logic           en;
  logic           reg_clear;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [NR-1:0]  valid_addr;
  logic [NR*AW-1:0] read_addr;
  logic [NR-1:0]  peek_en;
  logic [NR-1:0]  data_hit;
  logic [DW-1:0]  data;
  logic           busy;

  int n_cmp  = 0;
  int n_fail = 0;

  buffer_read_responder #(.DATA_WIDTH(8), .BUF_DEPTH(64), .NUM_ROUTERS(4)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_reg_clear(reg_clear),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_valid_addr(valid_addr), .i_read_addr(read_addr),
    .o_peek_en(peek_en), .o_data_hit(data_hit), .o_data(data), .o_busy(busy)
  );

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    read_addr[r*AW +: AW] = a;
  endtask

  task automatic soft_clear();
    @(negedge clk);
    reg_clear = 1'b1;
    @(negedge clk);
    reg_clear = 1'b0;
  endtask

  task automatic wait_peek(output bit to);
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (peek_en === 4'b1111) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Steps from PEEK through HIT and one cycle beyond, returning what was observed.
  task automatic run_txn(input bit drop_en, output bit to, output logic [NR-1:0] hit_h,
                         output logic [DW-1:0] data_h, output logic [NR-1:0] hit_n,
                         output logic [DW-1:0] data_n, output logic [NR-1:0] peek_sel);
    wait_peek(to);
    @(negedge clk);
    peek_sel = peek_en;
    @(negedge clk);
    @(negedge clk);
    hit_h  = data_hit;
    data_h = data;
    if (drop_en) en = 1'b0;
    @(negedge clk);
    hit_n  = data_hit;
    data_n = data;
    $display("txn: timeout=%0b hit=%b data=%h next_hit=%b next_data=%h", to, hit_h, data_h, hit_n, data_n);
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; reg_clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    valid_addr = '0; read_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (peek_en !== 4'b0000) begin n_fail++; $display("FAIL reset_peek: got %b expected 0000", peek_en); end
    n_cmp++; if (data_hit !== 4'b0000) begin n_fail++; $display("FAIL reset_hit: got %b expected 0000", data_hit); end
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    bit to; logic [NR-1:0] hh, hn, ps; logic [DW-1:0] dh, dn;
    load(6'd5, 8'h3C);
    valid_addr = 4'b0100; read_addr = '0; set_addr(2, 6'd5);
    en = 1'b1;
    run_txn(1'b1, to, hh, dh, hn, dn, ps);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_peek_timeout: got %b expected 0", to); end
    n_cmp++; if (ps !== 4'b0000) begin n_fail++; $display("FAIL single_peek_one_cycle: got %b expected 0000", ps); end
    n_cmp++; if (hh !== 4'b0100) begin n_fail++; $display("FAIL single_hit: got %b expected 0100", hh); end
    n_cmp++; if (dh !== 8'h3C) begin n_fail++; $display("FAIL single_data: got %h expected 3c", dh); end
    n_cmp++; if (hn !== 4'b0000) begin n_fail++; $display("FAIL single_hit_pulse: got %b expected 0000", hn); end
    n_cmp++; if (dn !== 8'h3C) begin n_fail++; $display("FAIL single_data_hold: got %h expected 3c", dn); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got %b expected 0", busy); end
  endtask

  task automatic test_multicast();
    bit to; logic [NR-1:0] hh, hn, ps, exp_hit; logic [DW-1:0] dh, dn;
`ifdef RESPONDER_MULTICAST_EN
    exp_hit = 4'b1011;
`else
    exp_hit = 4'b0001;
`endif
    soft_clear();
    load(6'd9, 8'hA5);
    load(6'd7, 8'h5A);
    valid_addr = 4'b1111;
    set_addr(0, 6'd9); set_addr(1, 6'd9); set_addr(2, 6'd7); set_addr(3, 6'd9);
    en = 1'b1;
    run_txn(1'b1, to, hh, dh, hn, dn, ps);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL mcast_timeout: got %b expected 0", to); end
    n_cmp++; if (hh !== exp_hit) begin n_fail++; $display("FAIL mcast_hit: got %b expected %b", hh, exp_hit); end
    n_cmp++; if (dh !== 8'hA5) begin n_fail++; $display("FAIL mcast_data: got %h expected a5", dh); end
  endtask

  task automatic test_round_robin();
    bit to; logic [NR-1:0] hh, hn, ps, exp_hit; logic [DW-1:0] dh, dn;
    logic [DW-1:0] exp_d [NR];
    exp_d = '{8'h10, 8'h21, 8'h32, 8'h43};
    soft_clear();
    for (int r = 0; r < NR; r++) load(AW'(10 + r), exp_d[r]);
    valid_addr = 4'b1111;
    for (int r = 0; r < NR; r++) set_addr(r, AW'(10 + r));
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_txn(k == 4, to, hh, dh, hn, dn, ps);
      exp_hit = 4'b0001 << (k % NR);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rr_timeout[%0d]: got %b expected 0", k, to); end
      n_cmp++; if (hh !== exp_hit) begin n_fail++; $display("FAIL rr_hit[%0d]: got %b expected %b", k, hh, exp_hit); end
      n_cmp++; if (dh !== exp_d[k % NR]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, dh, exp_d[k % NR]); end
    end
  endtask

  task automatic test_no_valid();
    bit to; logic [NR-1:0] exp_peek;
    soft_clear();
    valid_addr = 4'b0000;
    en = 1'b1;
    wait_peek(to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL idle_poll_timeout: got %b expected 0", to); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_peek = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      n_cmp++; if (peek_en !== exp_peek) begin n_fail++; $display("FAIL poll_peek[%0d]: got %b expected %b", k, peek_en, exp_peek); end
      n_cmp++; if (data_hit !== 4'b0000) begin n_fail++; $display("FAIL poll_hit[%0d]: got %b expected 0000", k, data_hit); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL poll_busy[%0d]: got %b expected 1", k, busy); end
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL poll_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_clear_mid();
    bit to; logic [NR-1:0] hh, hn, ps; logic [DW-1:0] dh, dn;
    valid_addr = 4'b0010; set_addr(1, 6'd5);
    en = 1'b1;
    run_txn(1'b0, to, hh, dh, hn, dn, ps);
    n_cmp++; if (hh !== 4'b0010) begin n_fail++; $display("FAIL clr_pre_hit: got %b expected 0010", hh); end
    n_cmp++; if (dh !== 8'h3C) begin n_fail++; $display("FAIL clr_pre_data: got %h expected 3c", dh); end
    valid_addr = 4'b1111;
    for (int r = 0; r < NR; r++) set_addr(r, AW'(10 + r));
    @(negedge clk);
    reg_clear = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", busy); end
    n_cmp++; if (peek_en !== 4'b0000) begin n_fail++; $display("FAIL clr_peek: got %b expected 0000", peek_en); end
    n_cmp++; if (data_hit !== 4'b0000) begin n_fail++; $display("FAIL clr_hit: got %b expected 0000", data_hit); end
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL clr_data: got %h expected 00", data); end
    reg_clear = 1'b0;
    run_txn(1'b1, to, hh, dh, hn, dn, ps);
    n_cmp++; if (hh !== 4'b0001) begin n_fail++; $display("FAIL clr_rr_restart_hit: got %b expected 0001", hh); end
    n_cmp++; if (dh !== 8'h10) begin n_fail++; $display("FAIL clr_rr_restart_data: got %h expected 10", dh); end
  endtask

  task automatic test_reset_mid();
    bit to; logic [NR-1:0] hh, hn, ps; logic [DW-1:0] dh, dn;
    valid_addr = 4'b0100; set_addr(2, 6'd5);
    en = 1'b1;
    wait_peek(to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout: got %b expected 0", to); end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b0; en = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hFF;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (data_hit !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_hit: got %b expected 0000", data_hit); end
    n_cmp++; if (peek_en !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_peek: got %b expected 0000", peek_en); end
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", data); end
    nrst = 1'b1; wr_en = 1'b0;
    en = 1'b1;
    run_txn(1'b1, to, hh, dh, hn, dn, ps);
    n_cmp++; if (hh !== 4'b0100) begin n_fail++; $display("FAIL rst_after_hit: got %b expected 0100", hh); end
    n_cmp++; if (dh !== 8'h3C) begin n_fail++; $display("FAIL rst_after_data: got %h expected 3c", dh); end
  endtask

  task automatic test_read_during_write();
    bit to; logic [NR-1:0] hh, hn, ps; logic [DW-1:0] dh, dn;
    load(6'd3, 8'h22);
    valid_addr = 4'b0001; read_addr = '0; set_addr(0, 6'd3);
    en = 1'b1;
    wait_peek(to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rdw_timeout: got %b expected 0", to); end
    @(negedge clk);
    @(negedge clk);
    // READ cycle: colliding write, and request inputs disturbed after sampling.
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h11;
    valid_addr = 4'b1000; set_addr(0, 6'd5);
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++; if (data_hit !== 4'b0001) begin n_fail++; $display("FAIL rdw_hit: got %b expected 0001", data_hit); end
    n_cmp++; if (data !== 8'h22) begin n_fail++; $display("FAIL rdw_old_data: got %h expected 22", data); end
    en = 1'b0;
    @(negedge clk);
    valid_addr = 4'b0001; set_addr(0, 6'd3);
    en = 1'b1;
    run_txn(1'b1, to, hh, dh, hn, dn, ps);
    n_cmp++; if (dh !== 8'h11) begin n_fail++; $display("FAIL rdw_new_data: got %h expected 11", dh); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multicast();
    test_round_robin();
    test_no_valid();
    test_clear_mid();
    test_reset_mid();
    test_read_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_read_responder.md
BUFFER_READ_RESPONDER -- requirements
Module: buffer_read_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, buffer word width.
REQ-002 SHALL have parameter BUF_DEPTH, default 64, buffer words; ADDR_WIDTH = $clog2(BUF_DEPTH).
REQ-003 SHALL have parameter NUM_ROUTERS, default 4, number of requesting row routers.
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_en  input  1  enables request servicing.
REQ-007 SHALL have port i_reg_clear  input  1  synchronous soft clear of control state.
REQ-008 SHALL have port i_wr_en  input  1  buffer load strobe.
REQ-009 SHALL have port i_wr_addr  input  ADDR_WIDTH  buffer load address.
REQ-010 SHALL have port i_wr_data  input  DATA_WIDTH  buffer load data.
REQ-011 SHALL have port i_valid_addr  input  NUM_ROUTERS  per-router peeked-address valid.
REQ-012 SHALL have port i_read_addr  input  NUM_ROUTERS*ADDR_WIDTH  per-router peeked address, router r at bits [r*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 SHALL have port o_peek_en  output  NUM_ROUTERS  peek request to every router.
REQ-014 SHALL have port o_data_hit  output  NUM_ROUTERS  one-cycle hit pulse per served router.
REQ-015 SHALL have port o_data  output  DATA_WIDTH  broadcast read data.
REQ-016 SHALL have port o_busy  output  1  high when FSM is not IDLE.

Function
REQ-017 SHALL hold BUF_DEPTH x DATA_WIDTH storage; write when i_wr_en, any state, one-cycle write.
REQ-018 SHALL implement FSM IDLE -> PEEK -> SELECT -> READ -> HIT -> PEEK.
REQ-019 IDLE: all outputs low except held o_data; go PEEK when i_en=1.
REQ-020 PEEK: o_peek_en all ones for exactly one cycle; go SELECT.
REQ-021 SELECT: register i_valid_addr/i_read_addr; pick winner as first valid router at or after rr_ptr (round-robin, wrap NUM_ROUTERS-1 -> 0); no valid router -> PEEK if i_en else IDLE.
REQ-022 READ: read storage at winner address, registered; same-cycle write to same address SHALL return old data.
REQ-023 HIT: o_data_hit pulsed one cycle for served routers; rr_ptr <= (winner+1) mod NUM_ROUTERS; go PEEK if i_en else IDLE.
REQ-024 o_data SHALL update on READ->HIT edge and hold until next READ->HIT edge (valid in HIT and the following cycle, since routers capture data one cycle after hit).
REQ-025 Request-to-hit latency SHALL be 4 cycles from PEEK entry (PEEK, SELECT, READ, HIT).
REQ-026 i_en deassert mid-transaction SHALL complete through HIT, then IDLE.
REQ-027 Only requests sampled in SELECT SHALL be considered; input changes in READ/HIT ignored.
REQ-028 i_reg_clear SHALL force IDLE, rr_ptr=0, o_data_hit=0, o_peek_en=0, o_data=0 next cycle; storage untouched; priority over i_en.

Reset
REQ-029 i_nrst=0 at rising edge SHALL force IDLE, rr_ptr=0, o_peek_en=0, o_data_hit=0, o_data=0, o_busy=0, including mid-transaction.
REQ-030 Storage contents SHALL NOT be reset; i_wr_en ignored while i_nrst=0.
REQ-031 Reset SHALL take priority over i_reg_clear.

Configuration
REQ-032 Macro RESPONDER_MULTICAST_EN defined: HIT SHALL pulse every router whose sampled valid=1 and address equals winner address.
REQ-033 Macro undefined: HIT SHALL pulse only the winner router; rr_ptr update identical.

Verification
REQ-034 Load addr 5=0x3C; router 2 valid addr 5, others invalid -> o_data_hit=4'b0100 in HIT, o_data=0x3C in HIT and next cycle.
REQ-035 Multicast: routers 0,1,3 valid addr 9 (=0xA5), router 2 valid addr 7 -> with macro hit=4'b1011, data 0xA5; without macro hit=4'b0001.
REQ-036 Round-robin: all four valid distinct addresses held constant -> winners 0,1,2,3,0 over five transactions.
REQ-037 No valid requests, i_en=1 -> PEEK/SELECT alternate, o_data_hit never asserted, o_busy=1.
REQ-038 i_nrst=0 during READ -> next cycle IDLE, all outputs 0, o_data=0; previously loaded data readable after reset.
REQ-039 Write 0x11 to addr 3 in READ cycle of read addr 3 (old 0x22) -> o_data=0x22; next read of addr 3 returns 0x11.
